// File: rtl/line_buffer_ntap.sv
// rtl/line_buffer_ntap.sv - parametrised N-tap line delay buffer with per-tap valid, sof resync and size clamp
module line_buffer_ntap #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_TAPS   = 2,
    parameter int MAX_LINE   = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           sof,
    input  logic [15:0]                    line_size,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps_out,
    output logic [NUM_TAPS-1:0]            taps_valid,
    output logic                           size_error
);

    localparam int LC_W = $clog2(NUM_TAPS + 1);
    localparam int LW   = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]          r_mem [NUM_TAPS][MAX_LINE];
    logic [DATA_WIDTH-1:0]          w_rd  [NUM_TAPS];
    logic [ADDR_WIDTH-1:0]          r_ptr;
    logic [ADDR_WIDTH-1:0]          w_addr;
    logic [ADDR_WIDTH-1:0]          w_ptr_next;
    logic [ADDR_WIDTH-1:0]          w_last_idx;
    logic                           w_wrap;
    logic [LW-1:0]                  r_len;
    logic [LW-1:0]                  w_new_len;
    logic                           w_new_err;
    logic                           r_len_err;
    logic                           r_in_reset;
    logic [LC_W-1:0]                r_lc;
    logic [NUM_TAPS*DATA_WIDTH-1:0] r_taps;
    logic [NUM_TAPS-1:0]            r_valid;

    // Zero or oversize line lengths fall back to the full memory depth.
    always_comb begin
        w_new_err = (line_size == 16'd0) || (32'(line_size) > MAX_LINE);
        w_new_len = w_new_err ? LW'(MAX_LINE) : LW'(line_size);
    end

    always_comb begin
        w_last_idx = ADDR_WIDTH'(r_len - 1'b1);
        w_addr     = sof ? '0 : r_ptr;
        w_wrap     = !sof && (r_ptr == w_last_idx);
        if (sof) begin
            w_ptr_next = (w_new_len == LW'(1)) ? '0 : ADDR_WIDTH'(1);
        end else if (r_ptr == w_last_idx) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_ptr + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_rd[k] = r_mem[k][w_addr];
        end
    end

    // Each line memory is fed by the old contents of the previous one at the same address.
    always_ff @(posedge clock) begin
        if (!reset && enable) begin
            r_mem[0][w_addr] <= data_in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                r_mem[k][w_addr] <= w_rd[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= '0;
            r_lc       <= '0;
            r_taps     <= '0;
            r_valid    <= '0;
            r_len      <= w_new_len;
            r_len_err  <= w_new_err;
            r_in_reset <= 1'b1;
        end else begin
            r_in_reset <= 1'b0;
            if (enable) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_taps[k*DATA_WIDTH +: DATA_WIDTH] <= w_rd[k];
                end
                r_ptr <= w_ptr_next;
                if (sof) begin
                    r_len     <= w_new_len;
                    r_len_err <= w_new_err;
                    r_lc      <= '0;
                    r_valid   <= '0;
                end else begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        r_valid[k] <= (r_lc > LC_W'(k));
                    end
                    if (w_wrap && (r_lc != LC_W'(NUM_TAPS))) begin
                        r_lc <= r_lc + 1'b1;
                    end
                end
            end
        end
    end

    // The error latched during reset only becomes visible once reset is released.
    assign size_error = r_len_err & ~r_in_reset;
    assign taps_out   = r_taps;
    assign taps_valid = r_valid;

endmodule

// File: tb/tb_line_buffer_ntap.sv
// tb/tb_line_buffer_ntap.sv - self-checking bench for line_buffer_ntap
module tb_line_buffer_ntap;

    localparam int DW = 12;
    localparam int NT = 2;
    localparam int ML = 4096;
    localparam int AW = 12;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             sof = 1'b0;
    logic [15:0]      line_size = 16'd8;
    logic [DW-1:0]    data_in = '0;
    logic [NT*DW-1:0] taps_out;
    logic [NT-1:0]    taps_valid;
    logic             size_error;

    line_buffer_ntap #(
        .DATA_WIDTH(DW),
        .NUM_TAPS  (NT),
        .MAX_LINE  (ML),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sof       (sof),
        .line_size (line_size),
        .data_in   (data_in),
        .taps_out  (taps_out),
        .taps_valid(taps_valid),
        .size_error(size_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: pixel history of the current frame, indexed by sample number.
    logic [DW-1:0] hist[$];
    int            m_len = ML;
    bit            m_pend = 1'b0;
    bit            m_in_reset = 1'b0;
    bit            e_err = 1'b0;
    logic [NT-1:0] e_valid = '0;
    logic [NT-1:0] e_chk = '0;
    logic [DW-1:0] e_tap [NT];

    typedef struct {
        bit          en;
        bit          sof;
        logic [15:0] ls;
        logic [DW-1:0] din;
        logic [1:0]  v;
        logic [DW-1:0] t0;
        logic [DW-1:0] t1;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_len(input logic [15:0] ls);
        return (ls == 16'd0 || int'(ls) > ML) ? ML : int'(ls);
    endfunction

    function automatic bit clamp_err(input logic [15:0] ls);
        return (ls == 16'd0 || int'(ls) > ML);
    endfunction

    task automatic step(input bit rst, input bit en, input bit s, input logic [15:0] ls,
                        input logic [DW-1:0] d);
        int n;
        int idx;
        reset = rst; enable = en; sof = s; line_size = ls; data_in = d;
        @(posedge clock);
        #1;
        if (rst) begin
            hist.delete();
            m_len      = clamp_len(ls);
            m_pend     = clamp_err(ls);
            m_in_reset = 1'b1;
            e_err      = 1'b0;
            e_valid    = '0;
            e_chk      = '1;
            for (int k = 0; k < NT; k++) e_tap[k] = '0;
        end else begin
            if (m_in_reset) begin
                e_err      = m_pend;
                m_in_reset = 1'b0;
            end
            if (en) begin
                if (s) begin
                    hist.delete();
                    m_len = clamp_len(ls);
                    e_err = clamp_err(ls);
                end
                n = hist.size();
                for (int k = 0; k < NT; k++) begin
                    idx        = n - (k + 1) * m_len;
                    e_valid[k] = !s && (idx >= 0);
                    e_chk[k]   = e_valid[k];
                    if (e_valid[k]) e_tap[k] = hist[idx];
                end
                hist.push_back(d);
            end
        end
        chk("model_valid", 32'(taps_valid), 32'(e_valid));
        chk("model_size_error", 32'(size_error), 32'(e_err));
        for (int k = 0; k < NT; k++) begin
            if (e_chk[k]) chk($sformatf("model_tap%0d", k), 32'(taps_out[k*DW +: DW]), 32'(e_tap[k]));
        end
    endtask

    task automatic do_reset(input logic [15:0] ls);
        step(1'b1, 1'b0, 1'b0, ls, '0);
        step(1'b1, 1'b0, 1'b0, ls, '0);
    endtask

    initial begin
        int cnt;
        logic [15:0] ls_r;
        bit en_r;
        bit s_r;

        tbl[0]  = '{1'b1, 1'b0, 16'd1, 12'd10, 2'b00, 12'd0,  12'd0};
        tbl[1]  = '{1'b1, 1'b0, 16'd1, 12'd11, 2'b01, 12'd10, 12'd0};
        tbl[2]  = '{1'b0, 1'b0, 16'd1, 12'd99, 2'b01, 12'd10, 12'd0};
        tbl[3]  = '{1'b1, 1'b0, 16'd1, 12'd12, 2'b11, 12'd11, 12'd10};
        tbl[4]  = '{1'b1, 1'b0, 16'd1, 12'd13, 2'b11, 12'd12, 12'd11};
        tbl[5]  = '{1'b0, 1'b1, 16'd1, 12'd55, 2'b11, 12'd12, 12'd11};
        tbl[6]  = '{1'b1, 1'b0, 16'd3, 12'd14, 2'b11, 12'd13, 12'd12};
        tbl[7]  = '{1'b1, 1'b1, 16'd3, 12'd30, 2'b00, 12'd0,  12'd0};
        tbl[8]  = '{1'b1, 1'b0, 16'd3, 12'd31, 2'b00, 12'd0,  12'd0};
        tbl[9]  = '{1'b1, 1'b0, 16'd3, 12'd32, 2'b00, 12'd0,  12'd0};
        tbl[10] = '{1'b1, 1'b0, 16'd3, 12'd33, 2'b01, 12'd30, 12'd0};
        tbl[11] = '{1'b1, 1'b0, 16'd3, 12'd34, 2'b01, 12'd31, 12'd0};
        tbl[12] = '{1'b1, 1'b0, 16'd3, 12'd35, 2'b01, 12'd32, 12'd0};
        tbl[13] = '{1'b1, 1'b0, 16'd3, 12'd36, 2'b11, 12'd33, 12'd30};

        // Reset state
        do_reset(16'd1);
        chk("reset_taps", 32'(taps_out), 32'd0);
        chk("reset_valid", 32'(taps_valid), 32'd0);
        chk("reset_size_error", 32'(size_error), 32'd0);

        // Table vectors: L=1, enable holds, sof without enable, line_size change without sof, sof resync
        for (int i = 0; i < 14; i++) begin
            step(1'b0, tbl[i].en, tbl[i].sof, tbl[i].ls, tbl[i].din);
            chk($sformatf("tbl%0d_valid", i), 32'(taps_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_size_error", i), 32'(size_error), 32'd0);
            if (tbl[i].v[0]) chk($sformatf("tbl%0d_tap0", i), 32'(taps_out[DW-1:0]), 32'(tbl[i].t0));
            if (tbl[i].v[1]) chk($sformatf("tbl%0d_tap1", i), 32'(taps_out[2*DW-1:DW]), 32'(tbl[i].t1));
        end

        // L=8 continuous stream, then mid-frame sof with line_size 4
        do_reset(16'd8);
        for (int p = 0; p < 20; p++) begin
            step(1'b0, 1'b1, 1'b0, 16'd8, DW'(p));
            if (p == 8) begin
                chk("l8_p8_tap0", 32'(taps_out[DW-1:0]), 32'd0);
                chk("l8_p8_valid", 32'(taps_valid), 32'b01);
            end
            if (p == 16) begin
                chk("l8_p16_tap1", 32'(taps_out[2*DW-1:DW]), 32'd0);
                chk("l8_p16_tap0", 32'(taps_out[DW-1:0]), 32'd8);
                chk("l8_p16_valid", 32'(taps_valid), 32'b11);
            end
        end
        step(1'b0, 1'b1, 1'b1, 16'd4, 12'd0);
        chk("sof_valid_drop", 32'(taps_valid), 32'd0);
        for (int q = 1; q <= 4; q++) step(1'b0, 1'b1, 1'b0, 16'd4, DW'(q));
        chk("sof_l4_tap0", 32'(taps_out[DW-1:0]), 32'd0);
        chk("sof_l4_valid", 32'(taps_valid), 32'b01);

        // Enable toggling: delays count enabled samples only
        do_reset(16'd8);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) begin
                step(1'b0, 1'b1, 1'b0, 16'd8, DW'(cnt));
                if (cnt == 16) begin
                    chk("tog_tap1", 32'(taps_out[2*DW-1:DW]), 32'd0);
                    chk("tog_tap0", 32'(taps_out[DW-1:0]), 32'd8);
                end
                cnt++;
            end else begin
                step(1'b0, 1'b0, 1'b0, 16'd8, 12'hABC);
            end
        end

        // Illegal sizes clamp to MAX_LINE
        for (int t = 0; t < 2; t++) begin
            ls_r = (t == 0) ? 16'd0 : 16'd5000;
            do_reset(ls_r);
            chk("clamp_reset_size_error", 32'(size_error), 32'd0);
            for (int i = 0; i <= 4096; i++) begin
                step(1'b0, 1'b1, 1'b0, ls_r, DW'(i + 7));
                if (i == 0) chk("clamp_size_error", 32'(size_error), 32'd1);
                if (i == 4095) chk("clamp_valid_4095", 32'(taps_valid), 32'd0);
                if (i == 4096) begin
                    chk("clamp_tap0_4096", 32'(taps_out[DW-1:0]), 32'd7);
                    chk("clamp_valid_4096", 32'(taps_valid), 32'b01);
                end
            end
        end
        step(1'b0, 1'b1, 1'b1, 16'd640, 12'd1);
        chk("sof640_size_error", 32'(size_error), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'd640, DW'(i + 2));

        // Reset beats sof and enable in the same cycle
        step(1'b1, 1'b1, 1'b1, 16'd2, 12'd5);
        chk("rst_win_taps", 32'(taps_out), 32'd0);
        chk("rst_win_valid", 32'(taps_valid), 32'd0);
        chk("rst_win_size_error", 32'(size_error), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'd2, DW'(100 + i));
            if (i == 2) chk("rst_win_ptr0_tap0", 32'(taps_out[DW-1:0]), 32'd100);
        end

        // Randomised frames against the model
        for (int f = 0; f < 6; f++) begin
            step(1'b0, 1'b1, 1'b1, 16'($urandom_range(2, 12)), DW'($urandom));
            for (int c = 0; c < 80; c++) begin
                en_r = ($urandom_range(0, 9) < 7);
                s_r  = ($urandom_range(0, 29) == 0);
                ls_r = s_r ? 16'($urandom_range(2, 12)) : 16'($urandom);
                step(1'b0, en_r, s_r, ls_r, DW'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buffer_ntap.md
Name: line_buffer_ntap

Overview:
- Parametrised multi-line delay buffer for the camera pixel pipeline, successor to the fixed two-line buffer.
- Supplies NUM_TAPS vertically aligned pixels (1..NUM_TAPS lines back) to downstream 2-D kernels (demosaic, filters).
- Adds:
  - configurable pixel width and tap count;
  - per-line size latched at frame start;
  - per-tap valid flags so consumers ignore unprimed taps;
  - start-of-frame resynchronisation;
  - a size-error flag.

Parameters:
- DATA_WIDTH, 12, pixel width in bits.
- NUM_TAPS, 2, number of line delays (1..8).
- MAX_LINE, 4096, depth of each line memory in pixels.
- ADDR_WIDTH, 12, pointer width; must satisfy 2^ADDR_WIDTH >= MAX_LINE.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  pixel strobe; only cycles with enable=1 advance state.
- sof  in  1  start of frame, qualified by enable; marks first pixel of a frame.
- line_size  in  16  active pixels per line; sampled only at reset release and on sof.
- data_in  in  DATA_WIDTH  input pixel.
- taps_out  out  NUM_TAPS*DATA_WIDTH  tap k in bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; tap k is the pixel k+1 lines earlier.
- taps_valid  out  NUM_TAPS  bit k high when tap k holds a pixel of the current frame.
- size_error  out  1  latched line_size was illegal and has been clamped.

Behaviour:
- Reset (reset=1 at a clock edge):
  - write pointer, line counter, taps_out, taps_valid and size_error all go to 0;
  - effective size L is loaded from line_size using the clamp rule below;
  - memory contents are not cleared; validity comes only from taps_valid.
- Clamp rule: line_size==0 or line_size>MAX_LINE gives L=MAX_LINE and size_error=1; otherwise L=line_size and size_error=0. size_error holds until the next latch point.
- Structure: NUM_TAPS single-port-style RAMs of MAX_LINE x DATA_WIDTH, cascaded, sharing one write pointer ptr.
- Each enable=1 cycle, for every k simultaneously, using the old value at ptr:
  - tap_k <= mem_k[ptr];
  - mem_k[ptr] <= (k==0 ? data_in : old mem_{k-1}[ptr]).
  - Read-before-write: tap k reflects the value before this cycle's write.
- Pointer: ptr <= (ptr==L-1) ? 0 : ptr+1. L=1 keeps ptr at 0, giving a 1-sample delay per tap.
- Latency: registered. After the edge that accepts pixel n, tap k equals pixel n-(k+1)*L (counted in enabled samples).
- enable=0: no state changes; taps_out and taps_valid hold.
- Line counter lc, saturating at NUM_TAPS:
  - increments on the enabled cycle where ptr==L-1 wraps;
  - taps_valid[k] is registered with the taps and equals (lc_before_cycle > k) on each enabled cycle.
  - So tap 0 first asserts valid with pixel n=L, i.e. the first pixel of line 1.
- sof with enable, same cycle:
  - latch L from line_size via the clamp rule;
  - treat the pixel as ptr=0: write it at address 0, set ptr<=1 (or 0 if the new L==1), set lc<=0;
  - taps_valid<=0 and taps_out are updated from address 0, then ignored.
  - sof without enable is ignored.
- Reset asserted mid-frame: takes priority over sof and enable; the next frame must start with sof or rely on lc=0 after reset.
- line_size changing without sof: no effect.
- Arithmetic: ptr compare uses ADDR_WIDTH bits. L is stored as ADDR_WIDTH+1 bits so MAX_LINE=2^ADDR_WIDTH is representable. lc width is clog2(NUM_TAPS+1).

Test Plan:
- Reset, line_size=8, NUM_TAPS=2, pixels 0,1,2,... with enable=1 continuously:
  - after pixel 8, tap0=0 and taps_valid=01;
  - after pixel 16, tap1=0, tap0=8, taps_valid=11;
  - steady state: tap0=n-8, tap1=n-16.
- Same stream with enable toggling 1,0,1,0: outputs hold on enable=0 cycles; delays in enabled samples are identical to the first test.
- Mid-frame sof at pixel 20 with line_size changed to 4: taps_valid drops to 00; pixel-value-0 of the new frame lands at address 0; tap0 valid 4 enabled pixels later, carrying the sof pixel.
- line_size=0 and line_size=5000 (MAX_LINE=4096), each latched at reset: size_error=1 and the delay is 4096. A later sof with line_size=640 clears size_error.
- line_size=1: tap0=n-1 and tap1=n-2; taps_valid=11 from the third pixel onward.
- reset asserted while sof=1 and enable=1: reset wins; all outputs 0 on the next cycle, ptr=0.
